// File: rtl/sha256_pad_stream.sv
`default_nettype none
// ============================================================================
// Module   : sha256_pad_stream
// Brief    : Byte stream to SHA-256 padded 32-bit word stream (0x80, zeros,
//            64-bit big-endian bit length), with block overflow handling.
// Revision : 1.0
// ============================================================================
module sha256_pad_stream #(
    parameter int BLK_W = 3
) (
    input  logic             clk,
    input  logic             rst,
    input  logic [7:0]       in_data,
    input  logic             in_valid,
    input  logic             in_last,
    output logic             in_ready,
    output logic [31:0]      out_word,
    output logic             out_valid,
    input  logic             out_ready,
    output logic [3:0]       out_word_idx,
    output logic [BLK_W-1:0] out_block_idx,
    output logic             out_block_end,
    output logic             msg_done,
    output logic             overflow
);
    localparam int CNT_W = BLK_W + 6;

    localparam logic [2:0] ST_ABSORB = 3'd0;
    localparam logic [2:0] ST_ZERO   = 3'd1;
    localparam logic [2:0] ST_LEN_HI = 3'd2;
    localparam logic [2:0] ST_LEN_LO = 3'd3;
    localparam logic [2:0] ST_DRAIN  = 3'd4;

    logic [2:0]       state_q, state_d;
    logic [1:0]       bp_q, bp_d;
    logic [23:0]      asm_q, asm_d;
    logic [CNT_W-1:0] cnt_q, cnt_d;
    logic [3:0]       word_idx_q, word_idx_d;
    logic [BLK_W-1:0] blk_idx_q, blk_idx_d;
    logic [31:0]      out_word_q, out_word_d;
    logic             out_valid_q, out_valid_d;
    logic             pend80_q, pend80_d;
    logic             last_seen_q, last_seen_d;
    logic             fin_q, fin_d;
    logic             msg_done_q, msg_done_d;
    logic             overflow_q, overflow_d;

    logic             w_hs;
    logic             w_free;
    logic             w_acc;
    logic             w_wrap;
    logic [3:0]       w_load_idx;
    logic [63:0]      w_bit_len;
    logic [31:0]      w_word;

    assign w_hs       = out_valid_q && out_ready;
    assign w_free     = !out_valid_q || out_ready;
    assign in_ready   = ((state_q == ST_ABSORB) && w_free) || (state_q == ST_DRAIN);
    assign w_acc      = in_valid && in_ready;
    // Index the next loaded word will carry; loads only happen when the register is free.
    assign w_load_idx = out_valid_q ? (word_idx_q + 4'd1) : word_idx_q;
    assign w_bit_len  = 64'({cnt_q, 3'b000});
    // The final length word never counts as a block wrap: a full-size message is legal.
    assign w_wrap     = w_hs && (word_idx_q == 4'hF) && (&blk_idx_q) && !fin_q;

    always_comb begin
        w_word = {asm_q, in_data};
        case (bp_q)
            2'd0:    w_word = {in_data, 8'h80, 16'h0000};
            2'd1:    w_word = {asm_q[23:16], in_data, 8'h80, 8'h00};
            2'd2:    w_word = {asm_q[23:8], in_data, 8'h80};
            default: w_word = {asm_q, in_data};
        endcase
    end

    always_comb begin
        state_d     = state_q;
        bp_d        = bp_q;
        asm_d       = asm_q;
        cnt_d       = cnt_q;
        word_idx_d  = word_idx_q;
        blk_idx_d   = blk_idx_q;
        out_word_d  = out_word_q;
        out_valid_d = out_valid_q;
        pend80_d    = pend80_q;
        last_seen_d = last_seen_q;
        fin_d       = fin_q;
        msg_done_d  = 1'b0;
        overflow_d  = overflow_q;

        if (w_hs) begin
            out_valid_d = 1'b0;
            word_idx_d  = word_idx_q + 4'd1;
            if (word_idx_q == 4'hF) begin
                blk_idx_d = blk_idx_q + BLK_W'(1);
            end
        end

        case (state_q)
            ST_ABSORB: begin
                if (w_acc) begin
                    cnt_d = (&cnt_q) ? cnt_q : (cnt_q + CNT_W'(1));
                    if (in_last) begin
                        last_seen_d = 1'b1;
                    end
                    if ((bp_q == 2'd3) || in_last) begin
                        out_word_d  = w_word;
                        out_valid_d = 1'b1;
                        bp_d        = 2'd0;
                        if (in_last && (bp_q == 2'd3)) begin
                            pend80_d = 1'b1;
                            state_d  = ST_ZERO;
                        end else if (in_last) begin
                            state_d = (w_load_idx == 4'd13) ? ST_LEN_HI : ST_ZERO;
                        end
                    end else begin
                        case (bp_q)
                            2'd0:    asm_d[23:16] = in_data;
                            2'd1:    asm_d[15:8]  = in_data;
                            default: asm_d[7:0]   = in_data;
                        endcase
                        bp_d = bp_q + 2'd1;
                    end
                end
            end
            ST_ZERO: begin
                if (w_free) begin
                    out_word_d  = pend80_q ? 32'h8000_0000 : 32'h0000_0000;
                    out_valid_d = 1'b1;
                    pend80_d    = 1'b0;
                    if (w_load_idx == 4'd13) begin
                        state_d = ST_LEN_HI;
                    end
                end
            end
            ST_LEN_HI: begin
                if (w_free) begin
                    out_word_d  = w_bit_len[63:32];
                    out_valid_d = 1'b1;
                    state_d     = ST_LEN_LO;
                end
            end
            ST_LEN_LO: begin
                if (fin_q && w_hs) begin
                    msg_done_d  = 1'b1;
                    fin_d       = 1'b0;
                    last_seen_d = 1'b0;
                    bp_d        = 2'd0;
                    cnt_d       = '0;
                    word_idx_d  = 4'd0;
                    blk_idx_d   = '0;
                    state_d     = ST_ABSORB;
                end else if (!fin_q && w_free) begin
                    out_word_d  = w_bit_len[31:0];
                    out_valid_d = 1'b1;
                    fin_d       = 1'b1;
                end
            end
            ST_DRAIN: begin
                if (w_acc && in_last) begin
                    state_d = ST_ABSORB;
                end
            end
            default: state_d = ST_ABSORB;
        endcase

        // Overflow abandons the rest of the message; any byte taken this cycle is dropped.
        if (w_wrap) begin
            overflow_d  = 1'b1;
            out_valid_d = 1'b0;
            bp_d        = 2'd0;
            cnt_d       = '0;
            word_idx_d  = 4'd0;
            blk_idx_d   = '0;
            pend80_d    = 1'b0;
            fin_d       = 1'b0;
            last_seen_d = 1'b0;
            state_d     = (last_seen_q || (w_acc && in_last)) ? ST_ABSORB : ST_DRAIN;
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state_q     <= ST_ABSORB;
            bp_q        <= 2'd0;
            asm_q       <= 24'd0;
            cnt_q       <= '0;
            word_idx_q  <= 4'd0;
            blk_idx_q   <= '0;
            out_word_q  <= 32'd0;
            out_valid_q <= 1'b0;
            pend80_q    <= 1'b0;
            last_seen_q <= 1'b0;
            fin_q       <= 1'b0;
            msg_done_q  <= 1'b0;
            overflow_q  <= 1'b0;
        end else begin
            state_q     <= state_d;
            bp_q        <= bp_d;
            asm_q       <= asm_d;
            cnt_q       <= cnt_d;
            word_idx_q  <= word_idx_d;
            blk_idx_q   <= blk_idx_d;
            out_word_q  <= out_word_d;
            out_valid_q <= out_valid_d;
            pend80_q    <= pend80_d;
            last_seen_q <= last_seen_d;
            fin_q       <= fin_d;
            msg_done_q  <= msg_done_d;
            overflow_q  <= overflow_d;
        end
    end

    assign out_word      = out_word_q;
    assign out_valid     = out_valid_q;
    assign out_word_idx  = word_idx_q;
    assign out_block_idx = blk_idx_q;
    assign out_block_end = out_valid_q && (word_idx_q == 4'hF);
    assign msg_done      = msg_done_q;
    assign overflow      = overflow_q;

endmodule
`default_nettype wire
